// File: rtl/rst_seq.sv
// Reset sequencer: debounces the power key, holds reset, then releases NumDomains
// reset domains in index order; supports per-domain software re-reset and power-loss abort.
module rst_seq #(
    parameter int NumDomains     = 3,
    parameter int Cycles         = 1024,
    parameter int DebounceCycles = 16,
    parameter int StageDelay     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  power,
    input  logic [NumDomains-1:0] sw_req,
    output logic [NumDomains-1:0] domain_rst_n,
    output logic                  ready,
    output logic [1:0]            cause
);

    localparam int MaxAB  = (Cycles > DebounceCycles) ? Cycles : DebounceCycles;
    localparam int MaxCnt = (MaxAB > StageDelay) ? MaxAB : StageDelay;
    localparam int CW     = $clog2(MaxCnt) + 1;
    localparam int IW     = (NumDomains > 1) ? $clog2(NumDomains) : 1;

    localparam logic [CW-1:0] DEB_M1   = CW'(DebounceCycles - 1);
    localparam logic [CW-1:0] CYC_M1   = CW'(Cycles - 1);
    localparam logic [CW-1:0] STG_M1   = CW'(StageDelay - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NumDomains - 1);

    localparam logic [1:0] CAUSE_LOSS = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;

    typedef enum logic [1:0] {
        WAIT_POWER = 2'd0,
        HOLD       = 2'd1,
        RELEASE    = 2'd2,
        RUN        = 2'd3
    } state_t;

    logic                  r_sync1;
    logic                  r_pwr_s;
    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         r_loss;
    logic [IW-1:0]         r_idx;
    logic [NumDomains-1:0] r_dom;
    logic                  r_ready;
    logic [1:0]            r_cause;

    state_t                w_state_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [CW-1:0]         w_loss_nxt;
    logic [IW-1:0]         w_idx_nxt;
    logic [NumDomains-1:0] w_dom_nxt;
    logic                  w_ready_nxt;
    logic [1:0]            w_cause_nxt;
    logic                  w_loss_trip;
    logic [IW-1:0]         w_sw_idx;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_pwr_s <= 1'b0;
        end else begin
            r_sync1 <= power;
            r_pwr_s <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_POWER;
            r_cnt   <= '0;
            r_loss  <= '0;
            r_idx   <= '0;
            r_dom   <= '0;
            r_ready <= 1'b0;
            r_cause <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_loss  <= w_loss_nxt;
            r_idx   <= w_idx_nxt;
            r_dom   <= w_dom_nxt;
            r_ready <= w_ready_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    // Lowest-index software request wins.
    always_comb begin
        w_sw_idx = '0;
        for (int k = NumDomains - 1; k >= 0; k--) begin
            if (sw_req[k]) w_sw_idx = IW'(k);
        end
    end

    assign w_loss_trip = (r_state != WAIT_POWER) && !r_pwr_s && (r_loss >= DEB_M1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_dom_nxt   = r_dom;
        w_cause_nxt = r_cause;
        w_loss_nxt  = (r_state == WAIT_POWER || r_pwr_s) ? '0 : sat_inc(r_loss);

        case (r_state)
            WAIT_POWER: begin
                w_dom_nxt = '0;
                if (r_pwr_s) begin
                    if (r_cnt >= DEB_M1) begin
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                    end else begin
                        w_cnt_nxt = sat_inc(r_cnt);
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            HOLD: begin
                if (r_cnt >= CYC_M1) begin
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = sat_inc(r_cnt);
                end
            end
            RELEASE: begin
                // r_cnt counts down the spacing to the next release.
                if (r_cnt == '0) begin
                    for (int k = 0; k < NumDomains; k++) begin
                        if (IW'(k) == r_idx) w_dom_nxt[k] = 1'b1;
                    end
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                        w_cnt_nxt = STG_M1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            RUN: begin
                if (|sw_req) begin
                    for (int k = 0; k < NumDomains; k++) begin
                        if (IW'(k) >= w_sw_idx) w_dom_nxt[k] = 1'b0;
                    end
                    w_cause_nxt = CAUSE_SW;
                    w_idx_nxt   = w_sw_idx;
                    w_cnt_nxt   = '0;
                    w_state_nxt = HOLD;
                end
            end
        endcase

        // Power loss overrides everything decided above, including a software request.
        if (w_loss_trip) begin
            w_state_nxt = WAIT_POWER;
            w_dom_nxt   = '0;
            w_cause_nxt = CAUSE_LOSS;
            w_cnt_nxt   = '0;
            w_loss_nxt  = '0;
        end

        w_ready_nxt = (r_state == RUN) && (w_state_nxt == RUN);
    end

    assign domain_rst_n = r_dom;
    assign ready        = r_ready;
    assign cause        = r_cause;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: directed test-plan steps plus random power/sw_req traffic against a
// release-schedule reference model.
module tb_rst_seq;

    localparam int NUM   = 3;
    localparam int CYC   = 8;
    localparam int DEB   = 4;
    localparam int SD    = 2;
    localparam int NEVER = 1 << 30;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           power = 1'b0;
    logic [NUM-1:0] sw_req = '0;
    logic [NUM-1:0] domain_rst_n;
    logic           ready;
    logic [1:0]     cause;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: release edge of each domain, edge where ready rises.
    int         m_t;
    logic       m_d1, m_d2;
    bit         m_on;
    int         m_hi, m_lo;
    int         m_rel [NUM];
    int         m_rdy_at;
    logic [1:0] m_cause;

    int burst;

    rst_seq #(
        .NumDomains    (NUM),
        .Cycles        (CYC),
        .DebounceCycles(DEB),
        .StageDelay    (SD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .power       (power),
        .sw_req      (sw_req),
        .domain_rst_n(domain_rst_n),
        .ready       (ready),
        .cause       (cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t      = -1;
        m_d1     = 1'b0;
        m_d2     = 1'b0;
        m_on     = 1'b0;
        m_hi     = 0;
        m_lo     = 0;
        m_rdy_at = NEVER;
        m_cause  = 2'b00;
        for (int k = 0; k < NUM; k++) m_rel[k] = NEVER;
    endtask

    // Schedule releases of domains first..NUM-1 after a hold of CYC cycles.
    task automatic schedule(input int first);
        for (int k = first; k < NUM; k++) m_rel[k] = m_t + CYC + 1 + (k - first) * SD;
        m_rdy_at = m_t + CYC + 1 + (NUM - 1 - first) * SD + 1;
    endtask

    task automatic model_edge();
        logic ps;
        int   low;
        m_t++;
        ps   = m_d2;
        m_d2 = m_d1;
        m_d1 = power;
        if (!m_on) begin
            m_hi = ps ? m_hi + 1 : 0;
            if (m_hi >= DEB) begin
                m_on = 1'b1;
                m_hi = 0;
                m_lo = 0;
                schedule(0);
            end
        end else begin
            m_lo = ps ? 0 : m_lo + 1;
            if (m_lo >= DEB) begin
                m_on     = 1'b0;
                m_lo     = 0;
                m_hi     = 0;
                m_rdy_at = NEVER;
                m_cause  = 2'b01;
                for (int k = 0; k < NUM; k++) m_rel[k] = NEVER;
            end else if (m_t >= m_rdy_at && sw_req != '0) begin
                low = 0;
                for (int k = NUM - 1; k >= 0; k--) if (sw_req[k]) low = k;
                schedule(low);
                m_cause = 2'b10;
            end
        end
    endtask

    task automatic step(input int n);
        logic [NUM-1:0] e_dom;
        for (int s = 0; s < n; s++) begin
            @(posedge clk);
            model_edge();
            #1;
            for (int k = 0; k < NUM; k++) e_dom[k] = (m_t >= m_rel[k]);
            chk("model_dom", 32'(domain_rst_n), 32'(e_dom));
            chk("model_ready", 32'(ready), 32'(m_t >= m_rdy_at));
            chk("model_cause", 32'(cause), 32'(m_cause));
            chk("monotone", 32'((domain_rst_n + 3'd1) & domain_rst_n), 32'd0);
        end
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dom", 32'(domain_rst_n), 32'd0);
        chk("arst_ready", 32'(ready), 32'd0);
        chk("arst_cause", 32'(cause), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        power  = 1'b1;
        sw_req = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("por_dom", 32'(domain_rst_n), 32'd0);
        chk("por_ready", 32'(ready), 32'd0);
        chk("por_cause", 32'(cause), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Power-up: bit0 at edge 14, bit1 at 16, bit2 at 18, ready at 19.
        step(14);
        chk("pu_e13", 32'(domain_rst_n), 32'b000);
        step(1);
        chk("pu_e14", 32'(domain_rst_n), 32'b001);
        step(2);
        chk("pu_e16", 32'(domain_rst_n), 32'b011);
        step(2);
        chk("pu_e18", 32'(domain_rst_n), 32'b111);
        chk("pu_e18_rdy", 32'(ready), 32'd0);
        step(1);
        chk("pu_e19_rdy", 32'(ready), 32'd1);
        chk("pu_cause", 32'(cause), 32'b00);

        // Short power glitch in RUN is filtered.
        power = 1'b0;
        step(3);
        power = 1'b1;
        step(6);
        chk("glitch_dom", 32'(domain_rst_n), 32'b111);
        chk("glitch_rdy", 32'(ready), 32'd1);

        // Software re-reset of domain 1.
        sw_req = 3'b010;
        step(1);
        sw_req = '0;
        chk("sw_dom", 32'(domain_rst_n), 32'b001);
        chk("sw_rdy", 32'(ready), 32'd0);
        chk("sw_cause", 32'(cause), 32'b10);
        step(8);
        chk("sw_s8", 32'(domain_rst_n), 32'b001);
        step(1);
        chk("sw_s9", 32'(domain_rst_n), 32'b011);
        step(2);
        chk("sw_s11", 32'(domain_rst_n), 32'b111);
        chk("sw_s11_rdy", 32'(ready), 32'd0);
        step(1);
        chk("sw_s12_rdy", 32'(ready), 32'd1);

        // Power loss reaching DEB on the same edge as sw_req=110.
        power = 1'b0;
        step(5);
        chk("sim_pre", 32'(domain_rst_n), 32'b111);
        sw_req = 3'b110;
        step(1);
        sw_req = '0;
        chk("sim_dom", 32'(domain_rst_n), 32'b000);
        chk("sim_cause", 32'(cause), 32'b01);
        chk("sim_rdy", 32'(ready), 32'd0);
        step(3);

        // Debounce glitch in WAIT_POWER delays domain 0 by 4 cycles.
        power = 1'b1;
        step(3);
        power = 1'b0;
        step(1);
        power = 1'b1;
        step(14);
        chk("deb_pre", 32'(domain_rst_n), 32'b000);
        step(1);
        chk("deb_b0", 32'(domain_rst_n), 32'b001);
        chk("deb_cause", 32'(cause), 32'b01);
        step(6);
        chk("deb_rdy", 32'(ready), 32'd1);

        // Async reset during RELEASE, then a full sequence again.
        sw_req = 3'b001;
        step(1);
        sw_req = '0;
        step(9);
        chk("mid_b0", 32'(domain_rst_n), 32'b001);
        async_reset();
        step(15);
        chk("mid_re_b0", 32'(domain_rst_n), 32'b001);
        step(5);
        chk("mid_re_all", 32'(domain_rst_n), 32'b111);
        chk("mid_re_rdy", 32'(ready), 32'd1);

        // Power loss during HOLD.
        sw_req = 3'b001;
        step(1);
        sw_req = '0;
        power = 1'b0;
        step(6);
        chk("hold_dom", 32'(domain_rst_n), 32'b000);
        chk("hold_cause", 32'(cause), 32'b01);
        power = 1'b1;
        step(14);
        chk("hold_pre", 32'(domain_rst_n), 32'b000);
        step(1);
        chk("hold_b0", 32'(domain_rst_n), 32'b001);
        step(5);
        chk("hold_rdy", 32'(ready), 32'd1);

        // Random traffic against the model.
        burst = 0;
        for (int it = 0; it < 1500; it++) begin
            if (burst > 0) begin
                burst--;
                power = 1'b0;
            end else if ($urandom_range(0, 99) < 4) begin
                burst = $urandom_range(0, 6);
                power = 1'b0;
            end else begin
                power = 1'b1;
            end
            sw_req = ($urandom_range(0, 99) < 6) ? NUM'($urandom_range(1, 7)) : '0;
            if ($urandom_range(0, 299) == 0) async_reset();
            step(1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
# rst_seq

Parametrised reset sequencer, successor to the single-output power-on reset generator. It debounces the raw power key and holds reset for a fixed time. It then releases `NumDomains` reset domains one at a time in index order (domain 0 first, e.g. debug module → memory/peripherals → hart), and supports per-domain software re-reset requests. It sits at the system top between the board key/reset and every block's `rst_n` input.

## Interface
- `NumDomains`, 3: number of reset domains, ≥1; domain k depends on all domains j<k.
- `Cycles`, 1024: reset hold time in cycles after debounce or software request, ≥1.
- `DebounceCycles`, 16: consecutive synchronized samples needed to accept a power level change, ≥1.
- `StageDelay`, 4: cycles between successive domain releases, ≥1.

- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `power`  in  1  raw, asynchronous power key; 1 = power present.
- `sw_req`  in  NumDomains  level software reset request per domain; sampled only in RUN.
- `domain_rst_n`  out  NumDomains  registered, active-low domain resets.
- `ready`  out  1  all domains released and sequencer in RUN.
- `cause`  out  2  last reset cause: 00 POR, 01 power loss, 10 software; held until the next event.

## Operation
- `power` passes through a 2-flop synchronizer; all logic below uses the synchronized value `pwr_s`.
- States: WAIT_POWER, HOLD, RELEASE, RUN. Reset state is WAIT_POWER.
- WAIT_POWER: all domains asserted.
  - Debounce counter increments on each edge with `pwr_s`=1 and clears on `pwr_s`=0.
  - On the edge where the count reaches `DebounceCycles`, go to HOLD with start index 0.
- HOLD: count `Cycles` edges, then go to RELEASE.
- RELEASE: release domain `start` on entry, then the next higher domain every `StageDelay` cycles. After the last domain is released, go to RUN.
- RUN: `ready`=1.
  - If any `sw_req` bit is set, the lowest set index i wins.
  - Domains i..NumDomains-1 are asserted on the next edge; domains <i stay released.
  - Then `cause`=10, `start`=i, go to HOLD.
- Power loss is detected in HOLD, RELEASE and RUN by a separate loss counter.
  - The counter counts consecutive `pwr_s`=0 edges.
  - At `DebounceCycles`, all domains are asserted, `cause`=01, go to WAIT_POWER.
- Power loss has priority over `sw_req` on the same edge.
- `sw_req` is ignored outside RUN. A request still held on entry to RUN re-triggers it, so software must drop the request.
- Counter width is $clog2 of the largest of `Cycles`, `DebounceCycles`, `StageDelay`, plus 1. Counters saturate and never wrap.

## Timing
- While `rst_n`=0: `domain_rst_n`=all 0, `ready`=0, `cause`=00, all counters and synchronizer flops 0, state WAIT_POWER.
- `rst_n` asserting mid-sequence aborts immediately, asynchronously, to the values above.
- Power-up, with `power` held high before `rst_n` rises:
  - `domain_rst_n[0]` rises 2+`DebounceCycles`+`Cycles` cycles after the first edge following `rst_n` release.
  - `domain_rst_n[k]` rises k·`StageDelay` cycles after domain 0.
  - `ready` rises 1 cycle after the last domain.
- Software request: affected domains fall 1 cycle after the `sw_req` sample edge; `ready` falls on the same edge.
  - Domain i rises `Cycles`+1 cycles after that sample edge.
  - Later domains follow at `StageDelay` spacing.
- Power loss: all `domain_rst_n` and `ready` fall 2+`DebounceCycles` cycles after raw `power` falls.
- Glitch tolerance:
  - A low pulse on `power` shorter than `DebounceCycles` cycles in RUN causes no reset.
  - A low pulse in WAIT_POWER restarts the debounce count.
- Domain outputs are monotone within a sequence: a domain is never released before all lower domains.

## Test plan
Bench settings: `NumDomains`=3, `Cycles`=8, `DebounceCycles`=4, `StageDelay`=2.
- Power-up: `power`=1, release `rst_n` → `domain_rst_n`=111 in steps: bit0 at cycle 14, bit1 at 16, bit2 at 18; `ready`=1 at 19; `cause`=00.
- Debounce: in WAIT_POWER, `power` low for 1 cycle after 3 high cycles → the count restarts and domain 0 release shifts by 4 cycles. In RUN, a 3-cycle low pulse → outputs unchanged.
- Software reset: in RUN, `sw_req`=010 for 1 cycle → `domain_rst_n`=001 next cycle, `ready`=0, `cause`=10; bit1 rises 9 cycles after the sample edge, bit2 2 cycles later, `ready` 1 cycle after that.
- Simultaneous events: `sw_req`=110 on the same edge the power-loss count reaches 4 → `domain_rst_n`=000, `cause`=01, state WAIT_POWER.
- Mid-operation reset: assert `rst_n` during RELEASE after bit0 is released → all outputs 0 and `cause`=00 asynchronously; full sequence repeats after release.
- Power loss in HOLD: drop `power` for 6 cycles during HOLD → `domain_rst_n` stays 000, `cause`=01, and the sequence restarts from WAIT_POWER when power returns.
